// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte stream to big-endian IMEM word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byte_in_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e FinState = CHK;
`else
  localparam state_e FinState = DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] idx_inc;

  assign xfer     = byte_valid_i && byte_ready_o;
  assign len_full = {len_q[15:8], byte_in_i};
  assign idx_inc  = idx_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN_HI;
          len_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in_i;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_in_i;
          if (len_full == 16'd0)
            state_d = FinState;
          else if (32'(len_full) > MAX_WORDS)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          data_d = {data_q[23:0], byte_in_i};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in_i;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
          end
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? FinState : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer)
          state_d = (byte_in_i == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status are decoded from the state register only.
  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    cpu_hold_o   = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (1'b1)
      (state_q == LEN_HI),
      (state_q == LEN_LO),
      (state_q == DATA),
      (state_q == CHK):   byte_ready_o = 1'b1;
      (state_q == WRITE): mem_we_o     = 1'b1;
      (state_q == DONE): begin
        cpu_hold_o = 1'b0;
        done_o     = 1'b1;
      end
      (state_q == ERR):   err_o        = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = data_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks with a write scoreboard for imem_loader.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic        bvalid = 1'b0;
  logic        byte_ready_o, mem_we_o, cpu_hold_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  int vec = 0;
  int mis = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  xsum;
  logic [63:0] e, o;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .byte_in_i(bin), .byte_valid_i(bvalid),
    .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_we_o === 1'b1) obs_q.push_back({mem_addr_o, mem_wdata_o});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    xsum = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bin = b; bvalid = 1'b1;
    while (byte_ready_o !== 1'b1) begin
      if (n == 20) begin
        $display("FAIL send_timeout: byte_ready stuck at %b for byte %h", byte_ready_o, b);
        $fatal(1, "handshake timeout");
      end
      tick(); n++;
    end
    tick();
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] w, input bit gap);
    exp_q.push_back({a, w});
    for (int i = 3; i >= 0; i--) begin
      send(w[8*i +: 8]);
      xsum ^= w[8*i +: 8];
      if (gap) begin bvalid = 1'b0; tick(); end
    end
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xsum);
`else
    tick();
`endif
    bvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bvalid = 1'b1; bin = 8'h55;
    tick();
    vec++;
    if ({byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, done_o, err_o}
        !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      mis++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b, want 0 0 0 0 1 0 0",
               byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, done_o, err_o);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    vec++;
    if (byte_ready_o !== 1'b0) begin
      mis++;
      $display("FAIL reset_beats_start: byte_ready=%b, want 0 (still IDLE)", byte_ready_o);
    end
    bvalid = 1'b0;
  endtask

  task automatic test_two_words();
    do_reset();
    pulse_start();
    send(8'h00); send(8'h02);
    send_word(BASE, 32'h0102_0304, 1'b0);
    vec++;
    if ({mem_we_o, byte_ready_o, done_o, cpu_hold_o} !== 4'b1001) begin
      mis++;
      $display("FAIL two_write_timing: we/rdy/done/hold=%b%b%b%b, want 1001",
               mem_we_o, byte_ready_o, done_o, cpu_hold_o);
    end
    send_word(BASE + 32'd4, 32'h0506_0708, 1'b0);
    finish_load();
    vec++;
    if ({done_o, cpu_hold_o, err_o, byte_ready_o} !== 4'b1000) begin
      mis++;
      $display("FAIL two_done: done/hold/err/rdy=%b%b%b%b, want 1000",
               done_o, cpu_hold_o, err_o, byte_ready_o);
    end
    vec++;
    if (obs_q.size() !== exp_q.size()) begin
      mis++;
      $display("FAIL two_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vec++;
      if (o !== e) begin
        mis++;
        $display("FAIL two_write: got %h/%h, want %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    pulse_start();
    send(8'h00); send(8'h00);
    finish_load();
    for (int i = 0; i < 2 && done_o !== 1'b1; i++) tick();
    vec++;
    if ({done_o, cpu_hold_o, err_o} !== 3'b100) begin
      mis++;
      $display("FAIL zero_done: done/hold/err=%b%b%b, want 100", done_o, cpu_hold_o, err_o);
    end
    vec++;
    if (obs_q.size() !== 0) begin
      mis++;
      $display("FAIL zero_nowrite: got %0d writes, want 0", obs_q.size());
    end
  endtask

  task automatic test_overlength();
    do_reset();
    pulse_start();
    send(8'h01); send(8'h01);
    bin = 8'hAA;
    vec++;
    if ({err_o, cpu_hold_o, byte_ready_o, done_o} !== 4'b1100) begin
      mis++;
      $display("FAIL ovl_err: err/hold/rdy/done=%b%b%b%b, want 1100",
               err_o, cpu_hold_o, byte_ready_o, done_o);
    end
    repeat (4) tick();
    vec++;
    if (obs_q.size() !== 0 || err_o !== 1'b1) begin
      mis++;
      $display("FAIL ovl_hold: got %0d writes err=%b, want 0 writes err=1", obs_q.size(), err_o);
    end
    bvalid = 1'b0;
    pulse_start();
    vec++;
    if ({err_o, byte_ready_o, cpu_hold_o, done_o} !== 4'b0110) begin
      mis++;
      $display("FAIL ovl_restart: err/rdy/hold/done=%b%b%b%b, want 0110",
               err_o, byte_ready_o, cpu_hold_o, done_o);
    end
  endtask

  task automatic test_max_words();
    logic [7:0] k;
    do_reset();
    pulse_start();
    send(8'h01); send(8'h00);
    for (int i = 0; i < MAXW; i++) begin
      k = 8'(i);
      send_word(BASE + 32'(4 * i), {k, ~k, 8'h5A, k ^ 8'h3C}, 1'b0);
    end
    finish_load();
    vec++;
    if ({done_o, err_o} !== 2'b10) begin
      mis++;
      $display("FAIL max_done: done/err=%b%b, want 10", done_o, err_o);
    end
    vec++;
    if (obs_q.size() !== exp_q.size()) begin
      mis++;
      $display("FAIL max_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vec++;
      if (o !== e) begin
        mis++;
        $display("FAIL max_write: got %h/%h, want %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_toggle_valid();
    do_reset();
    pulse_start();
    send(8'h00); bvalid = 1'b0; tick();
    send(8'h01); bvalid = 1'b0;
    pulse_start();
    send_word(BASE, 32'hDEAD_BEEF, 1'b1);
    finish_load();
    vec++;
    if ({done_o, cpu_hold_o} !== 2'b10) begin
      mis++;
      $display("FAIL toggle_done: done/hold=%b%b, want 10", done_o, cpu_hold_o);
    end
    vec++;
    if (obs_q.size() !== exp_q.size()) begin
      mis++;
      $display("FAIL toggle_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vec++;
      if (o !== e) begin
        mis++;
        $display("FAIL toggle_write: got %h/%h, want %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    pulse_start();
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD);
    bin = 8'hBE; rst = 1'b1;
    tick();
    vec++;
    if ({byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, done_o, err_o}
        !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      mis++;
      $display("FAIL midrst_outputs: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b, want 0 0 0 0 1 0 0",
               byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, done_o, err_o);
    end
    rst = 1'b0; bvalid = 1'b0;
    repeat (3) tick();
    vec++;
    if (obs_q.size() !== 0) begin
      mis++;
      $display("FAIL midrst_nowrite: got %0d writes, want 0", obs_q.size());
    end
    xsum = 8'h00;
    pulse_start();
    send(8'h00); send(8'h01);
    send_word(BASE, 32'hCAFE_BABE, 1'b0);
    finish_load();
    vec++;
    if (obs_q.size() !== exp_q.size() || done_o !== 1'b1) begin
      mis++;
      $display("FAIL midrst_reload: got %0d writes done=%b, want %0d writes done=1",
               obs_q.size(), done_o, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vec++;
      if (o !== e) begin
        mis++;
        $display("FAIL midrst_write: got %h/%h, want %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    do_reset();
    pulse_start();
    send(8'h00); send(8'h01);
    send_word(BASE, 32'h1122_3344, 1'b0);
    send(8'h00);
    bvalid = 1'b0;
    vec++;
    if ({err_o, done_o, cpu_hold_o} !== 3'b101) begin
      mis++;
      $display("FAIL badck_err: err/done/hold=%b%b%b, want 101", err_o, done_o, cpu_hold_o);
    end
    vec++;
    if (obs_q.size() !== exp_q.size()) begin
      mis++;
      $display("FAIL badck_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vec++;
      if (o !== e) begin
        mis++;
        $display("FAIL badck_write: got %h/%h, want %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_reset();
    test_zero_len();
    test_overlength();
    test_max_words();
    test_toggle_valid();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
